// File: rtl/cdc_toggle_sink.sv
// cdc_toggle_sink: receive endpoint of a toggle-handshake CDC; waits a settle time,
// captures the held payload, offers it on valid/ready and returns an ack toggle.
module cdc_toggle_sink #(
  parameter int WIDTH  = 32,
  parameter int SETTLE = 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             req_sync,
  input  logic [WIDTH-1:0] data,
  output logic             ack_toggle,
  output logic             deq_valid,
  input  logic             deq_ready,
  output logic [WIDTH-1:0] deq_bits,
  output logic             busy,
  output logic             proto_err
);
  typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_FULL} state_t;
  state_t           state_q, state_d;
  logic             req_seen_q, req_seen_d;
  logic [3:0]       cnt_q, cnt_d;
  logic             ack_q, ack_d;
  logic             err_q, err_d;
  logic [WIDTH-1:0] bits_q, bits_d;
  logic             pending;
  assign pending = req_sync != req_seen_q;
  always_comb begin
    state_d    = state_q;
    req_seen_d = req_seen_q;
    cnt_d      = cnt_q;
    ack_d      = ack_q;
    bits_d     = bits_q;
    err_d      = err_q | (state_q != S_IDLE && pending);
    case (state_q)
      S_IDLE: if (pending) begin
        req_seen_d = req_sync;
        if (SETTLE == 0) begin
          bits_d  = data;
          state_d = S_FULL;
        end else begin
          cnt_d   = 4'(SETTLE);
          state_d = S_SETTLE;
        end
      end
      S_SETTLE: if (cnt_q > 4'd1) cnt_d = cnt_q - 4'd1;
      else begin
        bits_d  = data;
        state_d = S_FULL;
      end
      S_FULL: if (deq_ready) begin
        ack_d   = ~ack_q;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= S_IDLE;
      req_seen_q <= 1'b0;
      cnt_q      <= 4'd0;
      ack_q      <= 1'b0;
      err_q      <= 1'b0;
      bits_q     <= '0;
    end else begin
      state_q    <= state_d;
      req_seen_q <= req_seen_d;
      cnt_q      <= cnt_d;
      ack_q      <= ack_d;
      err_q      <= err_d;
      bits_q     <= bits_d;
    end
  end
  assign ack_toggle = ack_q;
  assign deq_valid  = state_q == S_FULL;
  assign busy       = state_q != S_IDLE;
  assign deq_bits   = bits_q;
  assign proto_err  = err_q;
endmodule

// File: tb/tb_cdc_toggle_sink.sv
// tb_cdc_toggle_sink: scoreboard bench for cdc_toggle_sink with SETTLE = 1, 0 and 3 instances.
module tb_cdc_toggle_sink;
  logic clock = 0, reset = 1;
  logic req0 = 0, rdy0 = 0, ack0, val0, busy0, err0;
  logic [31:0] data0 = 0, bits0;
  logic req1 = 0, rdy1 = 0, ack1, val1, busy1, err1;
  logic [31:0] data1 = 0, bits1;
  logic req2 = 0, rdy2 = 0, ack2, val2, busy2, err2;
  logic [31:0] data2 = 0, bits2;
  int checks = 0, errors = 0;
  logic [31:0] exp_q[$];
  logic exp_ack = 0, flip_due = 0, prev_val = 0, prev_rdy = 0;

  always #5 clock = ~clock;

  cdc_toggle_sink #(.WIDTH(32), .SETTLE(1)) u0 (.clock(clock), .reset(reset), .req_sync(req0), .data(data0),
    .ack_toggle(ack0), .deq_valid(val0), .deq_ready(rdy0), .deq_bits(bits0), .busy(busy0), .proto_err(err0));
  cdc_toggle_sink #(.WIDTH(32), .SETTLE(0)) u1 (.clock(clock), .reset(reset), .req_sync(req1), .data(data1),
    .ack_toggle(ack1), .deq_valid(val1), .deq_ready(rdy1), .deq_bits(bits1), .busy(busy1), .proto_err(err1));
  cdc_toggle_sink #(.WIDTH(32), .SETTLE(3)) u2 (.clock(clock), .reset(reset), .req_sync(req2), .data(data2),
    .ack_toggle(ack2), .deq_valid(val2), .deq_ready(rdy2), .deq_bits(bits2), .busy(busy2), .proto_err(err2));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Monitor: pops the scoreboard on every handshake and checks the ack flip that follows.
  always @(negedge clock) begin
    if (reset) begin
      exp_ack  = 0;
      flip_due = 0;
      prev_val = 0;
    end else begin
      if (flip_due) begin
        chk("ack_flip", {31'b0, ack0}, {31'b0, exp_ack});
        flip_due = 0;
      end
      if (prev_val && !prev_rdy && !val0) chk("valid_hold", {31'b0, val0}, 32'd1);
      if (val0 && rdy0) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_pop: got %h expected no transfer", bits0);
        end else chk("deq_bits", bits0, exp_q.pop_front());
        exp_ack  = ~exp_ack;
        flip_due = 1;
      end
      prev_val = val0;
      prev_rdy = rdy0;
    end
  end

  initial begin
    repeat (3) tick();
    reset = 0;
    repeat (10) tick();
    chk("rst_valid", {31'b0, val0}, 0);
    chk("rst_ack", {31'b0, ack0}, 0);
    chk("rst_busy", {31'b0, busy0}, 0);
    chk("rst_err", {31'b0, err0}, 0);
    chk("rst_bits", bits0, 0);
    req1 = 1; data1 = 32'h0BADF00D;
    tick();
    chk("s0_latency_valid", {31'b0, val1}, 1);
    chk("s0_bits", bits1, 32'h0BADF00D);
    rdy1 = 1;
    tick();
    chk("s0_ack", {31'b0, ack1}, 1);
    chk("s0_valid_fall", {31'b0, val1}, 0);
    req2 = 1; data2 = 32'h0;
    tick();
    data2 = 32'h11111111;
    tick();
    data2 = 32'hCAFEF00D;
    tick();
    chk("s3_not_yet", {31'b0, val2}, 0);
    tick();
    chk("s3_latency_valid", {31'b0, val2}, 1);
    chk("s3_capture", bits2, 32'hCAFEF00D);
    rdy2 = 1;
    tick();
    chk("s3_ack", {31'b0, ack2}, 1);
    rdy0 = 1; req0 = 1; data0 = 32'hDEADBEEF; exp_q.push_back(32'hDEADBEEF);
    tick();
    chk("busy_rise", {31'b0, busy0}, 1);
    chk("valid_early", {31'b0, val0}, 0);
    tick();
    chk("valid_rise", {31'b0, val0}, 1);
    tick();
    chk("ack_1", {31'b0, ack0}, 1);
    chk("valid_fall", {31'b0, val0}, 0);
    chk("busy_fall", {31'b0, busy0}, 0);
    req0 = 0; data0 = 32'h12345678; exp_q.push_back(32'h12345678);
    repeat (3) tick();
    chk("ack_0", {31'b0, ack0}, 0);
    rdy0 = 0; req0 = 1; data0 = 32'hDEADBEEF; exp_q.push_back(32'hDEADBEEF);
    repeat (2) tick();
    data0 = 32'h0;
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("bp_bits", bits0, 32'hDEADBEEF);
      chk("bp_ack", {31'b0, ack0}, 0);
      chk("bp_valid", {31'b0, val0}, 1);
    end
    rdy0 = 1;
    tick();
    chk("bp_pop_ack", {31'b0, ack0}, 1);
    chk("bp_pop_valid", {31'b0, val0}, 0);
    tick();
    chk("bp_single_flip", {31'b0, ack0}, 1);
    rdy0 = 0; req0 = 0; data0 = 32'hA5A5A5A5; exp_q.push_back(32'hA5A5A5A5);
    repeat (2) tick();
    chk("err_clear", {31'b0, err0}, 0);
    req0 = 1;
    tick();
    chk("err_set", {31'b0, err0}, 1);
    req0 = 0;
    tick();
    rdy0 = 1;
    tick();
    repeat (2) tick();
    chk("even_no_pending", {31'b0, busy0}, 0);
    chk("err_sticky", {31'b0, err0}, 1);
    chk("even_ack", {31'b0, ack0}, 0);
    rdy0 = 0; req0 = 1; data0 = 32'h11111111; exp_q.push_back(32'h11111111);
    repeat (2) tick();
    req0 = 0;
    tick();
    data0 = 32'h22222222; exp_q.push_back(32'h22222222); rdy0 = 1;
    repeat (5) tick();
    chk("odd_ack", {31'b0, ack0}, 0);
    chk("odd_idle", {31'b0, busy0}, 0);
    chk("queue_drained", exp_q.size(), 0);
    rdy0 = 0; req0 = 1; data0 = 32'h00000077;
    tick();
    chk("pre_rst_settle", {31'b0, busy0}, 1);
    reset = 1; req0 = 0;
    tick();
    reset = 0;
    chk("rst_settle_busy", {31'b0, busy0}, 0);
    chk("rst_settle_valid", {31'b0, val0}, 0);
    chk("rst_settle_err", {31'b0, err0}, 0);
    chk("rst_settle_ack", {31'b0, ack0}, 0);
    rdy0 = 1; req0 = 1; data0 = 32'h33333333; exp_q.push_back(32'h33333333);
    repeat (3) tick();
    chk("pre_full_ack", {31'b0, ack0}, 1);
    rdy0 = 0; req0 = 0; data0 = 32'h00000044;
    repeat (2) tick();
    chk("pre_rst_full", {31'b0, val0}, 1);
    reset = 1;
    tick();
    reset = 0;
    exp_q.delete();
    chk("rst_full_ack", {31'b0, ack0}, 0);
    chk("rst_full_valid", {31'b0, val0}, 0);
    chk("rst_full_busy", {31'b0, busy0}, 0);
    chk("rst_full_err", {31'b0, err0}, 0);
    repeat (3) tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
